// File: rtl/display_scan.sv
// Time-multiplexed 4-digit common-anode 7-segment driver for the clock display bus.
// Captures the selected pair values once per scan frame and renders them as BCD.
module display_scan #(
  parameter int unsigned SCAN_DIV = 4,
  parameter bit          LZ_BLANK = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] val_hi,
  input  logic [5:0] val_lo,
  input  logic       page,
  input  logic       blank,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       frame_start
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic [5:0]    sh_hi;
  logic [5:0]    sh_lo;
  logic          sh_page;
  logic          load_pending;

  logic          tick_c;
  logic          load_c;
  logic [5:0]    cur_val_c;
  logic [3:0]    tens_c;
  logic [3:0]    ones_c;
  logic [3:0]    digit_c;
  logic [6:0]    seg_c;
  logic          dp_c;
  logic [3:0]    an_c;

  // Tens digit of a 0..59 value; anything larger is flagged as a dash by the caller.
  function automatic logic [3:0] tens_of(input logic [5:0] v);
    logic [3:0] t;
    t = 4'd0;
    if (v >= 6'd50)      t = 4'd5;
    else if (v >= 6'd40) t = 4'd4;
    else if (v >= 6'd30) t = 4'd3;
    else if (v >= 6'd20) t = 4'd2;
    else if (v >= 6'd10) t = 4'd1;
    return t;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    s = SEG_OFF;
    case (d)
      4'd0: s = 7'b1000000;
      4'd1: s = 7'b1111001;
      4'd2: s = 7'b0100100;
      4'd3: s = 7'b0110000;
      4'd4: s = 7'b0011001;
      4'd5: s = 7'b0010010;
      4'd6: s = 7'b0000010;
      4'd7: s = 7'b1111000;
      4'd8: s = 7'b0000000;
      4'd9: s = 7'b0010000;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  assign tick_c = (presc == PRESC_MAX);
  assign load_c = load_pending | (tick_c & (idx == 2'd3));

  // Digit selection and segment rendering for the current slot
  always_comb begin
    cur_val_c = idx[1] ? sh_hi : sh_lo;
    tens_c    = tens_of(cur_val_c);
    ones_c    = 4'(cur_val_c - (6'({tens_c, 3'b000}) + 6'({tens_c, 1'b0})));
    digit_c   = idx[0] ? tens_c : ones_c;
    seg_c     = seg_of(digit_c);
    dp_c      = ~((idx == 2'd2) | ((idx == 2'd0) & sh_page));
    an_c      = ~(4'b0001 << idx);
    if (cur_val_c > 6'd59) begin
      seg_c = SEG_DASH;
    end else if (LZ_BLANK && (idx == 2'd3) && (digit_c == 4'd0)) begin
      seg_c = SEG_OFF;
      dp_c  = 1'b1;
    end
    if (blank) begin
      seg_c = SEG_OFF;
      dp_c  = 1'b1;
      an_c  = 4'hF;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc        <= '0;
      idx          <= 2'd0;
      sh_hi        <= 6'd0;
      sh_lo        <= 6'd0;
      sh_page      <= 1'b0;
      load_pending <= 1'b1;
      seg          <= SEG_OFF;
      dp           <= 1'b1;
      an           <= 4'hF;
      frame_start  <= 1'b0;
    end else begin
      presc        <= tick_c ? '0 : presc + PW'(1);
      if (tick_c) idx <= idx + 2'd1;
      // Shadow capture happens only at frame boundaries so a page switch never tears a frame
      if (load_c) begin
        sh_hi   <= val_hi;
        sh_lo   <= val_lo;
        sh_page <= page;
      end
      load_pending <= 1'b0;
      seg          <= seg_c;
      dp           <= dp_c;
      an           <= an_c;
      frame_start  <= load_c;
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// Bench for display_scan: a table of opening vectors, directed corner sequences and
// random stimulus, all compared against a cycle-count based display model.
module tb_display_scan;

  localparam int SD = 4;
  localparam int P  = 4 * SD;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] val_hi, val_lo;
  logic       page, blank;
  logic [6:0] seg0, seg1;
  logic       dp0, dp1, fs0, fs1;
  logic [3:0] an0, an1;

  display_scan #(.SCAN_DIV(SD), .LZ_BLANK(1'b0)) u_dut (
    .clk(clk), .reset(reset), .val_hi(val_hi), .val_lo(val_lo), .page(page),
    .blank(blank), .seg(seg0), .dp(dp0), .an(an0), .frame_start(fs0));

  display_scan #(.SCAN_DIV(SD), .LZ_BLANK(1'b1)) u_dut_lz (
    .clk(clk), .reset(reset), .val_hi(val_hi), .val_lo(val_lo), .page(page),
    .blank(blank), .seg(seg1), .dp(dp1), .an(an1), .frame_start(fs1));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Model state: k = cycles elapsed since reset released, plus captured frame values
  int         k = 0;
  logic       pend = 1'b1;
  logic [5:0] m_hi = 6'd0, m_lo = 6'd0;
  logic       m_pg = 1'b0;
  logic [6:0] seg_codes [10];

  typedef struct {
    logic       rst;
    logic [5:0] hi, lo;
    logic       pg, bl;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       fs;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [11:0] disp(input bit lz, input logic bl);
    int idx, v, d;
    logic [6:0] s;
    logic dpv;
    logic [3:0] a;
    if (bl) return {7'h7F, 1'b1, 4'hF};
    idx = (k / SD) % 4;
    v = (idx >= 2) ? int'(m_hi) : int'(m_lo);
    dpv = !((idx == 2) || (idx == 0 && m_pg));
    a = 4'hF;
    a[idx] = 1'b0;
    if (v > 59) s = 7'b0111111;
    else begin
      d = (idx % 2 == 0) ? v % 10 : v / 10;
      s = seg_codes[d];
      if (lz && idx == 3 && d == 0) begin
        s = 7'h7F;
        dpv = 1'b1;
      end
    end
    return {s, dpv, a};
  endfunction

  // One clock: drive inputs, predict both DUTs' outputs, advance model, compare
  task automatic step(input logic r, input logic [5:0] h, input logic [5:0] l,
                      input logic pg, input logic bl);
    logic [12:0] e0, e1;
    logic efs;
    reset = r; val_hi = h; val_lo = l; page = pg; blank = bl;
    if (r) begin
      e0 = {7'h7F, 1'b1, 4'hF, 1'b0};
      e1 = e0;
      k = 0; pend = 1'b1; m_hi = 6'd0; m_lo = 6'd0; m_pg = 1'b0;
    end else begin
      efs = pend || (k % P == P - 1);
      e0 = {disp(1'b0, bl), efs};
      e1 = {disp(1'b1, bl), efs};
      if (efs) begin
        m_hi = h; m_lo = l; m_pg = pg;
      end
      pend = 1'b0;
      k++;
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("dut_outputs", 32'({seg0, dp0, an0, fs0}), 32'(e0));
    chk("dut_lz_outputs", 32'({seg1, dp1, an1, fs1}), 32'(e1));
  endtask

  initial begin
    int last_fs;
    int guard;
    seg_codes = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    tbl[0] = '{1'b1, 6'd12, 6'd34, 1'b0, 1'b0, 7'h7F, 1'b1, 4'hF, 1'b1 ^ 1'b1};
    tbl[1] = '{1'b0, 6'd12, 6'd34, 1'b0, 1'b0, 7'h40, 1'b1, 4'hE, 1'b1};
    for (int i = 2; i < 5; i++) tbl[i] = '{1'b0, 6'd12, 6'd34, 1'b0, 1'b0, 7'h19, 1'b1, 4'hE, 1'b0};
    for (int i = 5; i < 9; i++) tbl[i] = '{1'b0, 6'd12, 6'd34, 1'b0, 1'b0, 7'h30, 1'b1, 4'hD, 1'b0};
    tbl[9] = '{1'b0, 6'd12, 6'd34, 1'b0, 1'b0, 7'h24, 1'b0, 4'hB, 1'b0};

    reset = 1'b1; val_hi = 6'd0; val_lo = 6'd0; page = 1'b0; blank = 1'b0;
    @(posedge clk);
    #1;

    // Opening vectors after reset
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].rst, tbl[i].hi, tbl[i].lo, tbl[i].pg, tbl[i].bl);
      chk("table", 32'({seg0, dp0, an0, fs0}),
          32'({tbl[i].seg, tbl[i].dp, tbl[i].an, tbl[i].fs}));
    end

    // Mid-frame value change must wait for the frame boundary
    guard = 0;
    while (((k / SD) % 4) != 1 && guard < 64) begin step(1'b0, 6'd12, 6'd34, 1'b0, 1'b0); guard++; end
    for (int i = 0; i < 40; i++) step(1'b0, 6'd12, 6'd59, 1'b0, 1'b0);

    // Out-of-range pair shows dashes
    for (int i = 0; i < 40; i++) step(1'b0, 6'd60, 6'd7, 1'b0, 1'b0);

    // Hours page indicator and leading-zero blanking
    for (int i = 0; i < 40; i++) step(1'b0, 6'd9, 6'd5, 1'b1, 1'b0);

    // Blank for 10 cycles mid-frame; frame period must stay at P
    last_fs = -1;
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 6'd23, 6'd45, 1'b0, (i >= 6 && i < 16) ? 1'b1 : 1'b0);
      if (fs0) begin
        if (last_fs >= 0) chk("frame_period", 32'(cyc - last_fs), 32'(P));
        last_fs = cyc;
      end
    end

    // One-cycle reset at index 2, then a fresh load on release
    guard = 0;
    while (((k / SD) % 4) != 2 && guard < 64) begin step(1'b0, 6'd23, 6'd45, 1'b0, 1'b0); guard++; end
    step(1'b1, 6'd23, 6'd45, 1'b0, 1'b0);
    chk("an_in_reset", 32'(an0), 32'(4'hF));
    step(1'b0, 6'd58, 6'd1, 1'b1, 1'b0);
    chk("fs_after_reset", 32'(fs0), 32'(1'b1));
    for (int i = 0; i < 20; i++) step(1'b0, 6'd0, 6'd0, 1'b0, 1'b0);

    // Random stimulus
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
           6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
